div_iter: RTL
=============

DIV_ITER -- requirements
Module: div_iter

Interface
- REQ-001 Parameter WIDTH, default 32, operand width in bits; legal values are 2 and above.
- REQ-002 Single clock; reset is synchronous and active-low.
- REQ-003 clk  input  1  clock; all state updates on the rising edge.
- REQ-004 rst  input  1  synchronous active-low reset.
- REQ-005 signed_div_i  input  1  selects the operand interpretation: 1 = two's-complement signed, 0 = unsigned.
- REQ-006 opdata1_i  input  WIDTH  dividend.
- REQ-007 opdata2_i  input  WIDTH  divisor.
- REQ-008 start_i  input  1  request a division; level-held by the requester until ready_o is seen.
- REQ-009 annul_i  input  1  abort the division in progress (pipeline flush).
- REQ-010 result_o  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
- REQ-011 ready_o  output  1  result_o is valid.

Function
- REQ-012 The state machine SHALL have four states: FREE, BYZERO, ON, END. All outputs SHALL be registered.
- REQ-013 FREE, with start_i=1, annul_i=0 and opdata2_i=0: go to BYZERO.
- REQ-014 FREE, with start_i=1, annul_i=0 and opdata2_i!=0: latch the operands and go to ON, with iteration counter cnt=0.
  - If signed_div_i=1, latch the magnitudes of negative operands.
- REQ-015 FREE with start_i=0 or annul_i=1: stay in FREE with ready_o=0 and result_o=0.
- REQ-016 BYZERO: go to END with quotient=0 and remainder=0.
- REQ-017 ON, annul_i=0: perform one restoring shift-subtract step per cycle and produce one quotient bit, MSB first.
  - Increment cnt each step.
  - cnt SHALL be $clog2(WIDTH)+1 bits wide.
- REQ-018 ON, cnt==WIDTH: apply the sign correction and go to END.
  - Quotient is negated iff signed_div_i=1 and the operand signs differ.
  - Remainder is negated iff signed_div_i=1 and the dividend is negative.
- REQ-019 ON with annul_i=1: go to FREE at the next edge, with ready_o=0 and result_o=0 and no result produced.
- REQ-020 END: hold ready_o=1 and result_o stable while start_i=1.
- REQ-021 END with start_i=0: go to FREE, with ready_o=0 and result_o=0 at that edge.
- REQ-022 In END, annul_i SHALL be ignored.
- REQ-023 Latency, counted from the edge that samples start_i in FREE:
  - ready_o is first 1 after exactly WIDTH+2 edges for a nonzero divisor.
  - ready_o is first 1 after exactly 2 edges for a zero divisor.
- REQ-024 Operand changes after the start edge SHALL NOT affect the result.
- REQ-025 Signed most-negative divided by -1 SHALL wrap: quotient = 2^(WIDTH-1) bit pattern, remainder = 0.
- REQ-026 signed_div_i is sampled at the start edge only.
- REQ-027 Unsigned results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor.
- REQ-028 A new start SHALL be accepted only from FREE. A start_i held through END therefore does not retrigger a second division.

Reset
- REQ-029 rst=0 at any edge SHALL force state FREE, cnt=0, ready_o=0, result_o=0 and clear the internal dividend/divisor registers.
- REQ-030 Reset SHALL override every other input in every state, including mid-ON and END.
- REQ-031 The first start SHALL be accepted on the first edge with rst=1.

Verification (WIDTH=32)
- REQ-032 Unsigned 100/7:
  - Stimulus: start=1, signed=0.
  - Response: ready_o rises after 34 edges with result_o = {32'h00000002, 32'h0000000E}; ready_o falls one edge after start drops.
- REQ-033 Signed -7/2 (32'hFFFFFFF9 / 32'h00000002):
  - Response: result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}.
  - Also check 32'h80000000 / 32'hFFFFFFFF, which gives {32'h0, 32'h80000000}.
- REQ-034 Divide by zero, 5/0:
  - Response: ready_o=1 after 2 edges with result_o=0.
  - Holding start keeps ready_o=1 with no retrigger.
- REQ-035 Annul:
  - Stimulus: assert annul_i for one cycle 10 edges into ON.
  - Response: FREE next edge, ready_o stays 0 for 40 cycles.
  - A fresh 9/3 start afterwards yields {0, 3}.
- REQ-036 Reset:
  - Stimulus: rst=0 mid-ON, and again in END.
  - Response: next edge ready_o=0 and result_o=0.
  - After release, 0xFFFFFFFF/1 (unsigned) yields {0, 32'hFFFFFFFF}.
- REQ-037 Random check: 10k random operand pairs over both modes, checked against a reference model. Repeat with WIDTH=8 and WIDTH=2.

Source files
------------

// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, signed or unsigned operands.
// Result is {remainder, quotient} and is held with ready_o while start_i stays high.
module div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic [WIDTH:0]       partial;
    logic [WIDTH:0]       diff;
    logic                 fits;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    // Quotient bits shift out of quo_q into the partial remainder as new bits shift in.
    always_comb begin
        partial = {rem_q, quo_q[WIDTH-1]};
        diff    = partial - {1'b0, divisor_q};
        fits    = (partial >= {1'b0, divisor_q});
        mag1    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        mag2    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        quo_fix = neg_quo_q ? -quo_q : quo_q;
        rem_fix = neg_rem_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = '0;
        ready_d   = 1'b0;

        unique case (state_q)
            FREE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d   = ON;
                        cnt_d     = '0;
                        quo_d     = mag1;
                        divisor_d = mag2;
                        rem_d     = '0;
                        neg_quo_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem_d = signed_div_i && opdata1_i[WIDTH-1];
                    end
                end
            end
            BYZERO: begin
                state_d = END;
                ready_d = 1'b1;
            end
            ON: begin
                if (annul_i) begin
                    state_d = FREE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d  = END;
                    ready_d  = 1'b1;
                    result_d = {rem_fix, quo_fix};
                end else begin
                    quo_d = {quo_q[WIDTH-2:0], fits};
                    rem_d = fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            END: begin
                // annul_i has no effect once the result exists.
                if (start_i) begin
                    ready_d  = 1'b1;
                    result_d = result_q;
                end else begin
                    state_d = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
